// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: CPU-side instruction/data RAM responder with byte loader and output register
//   CK, RST                     clock, async active-high reset
//   IA -> ID                    combinational instruction fetch from imem
//   DA, DD, RW                  data bus; block drives DD only while RW=1
//   LD_EN, LD_VALID, LD_DATA    byte-wide program loader (high byte first)
//   LD_READY, LD_COUNT          loader handshake and words written this session
//   CPU_RST                     holds the CPU in reset except after a finished load
//   OUT                         memory-mapped output register at OUT_ADDR
module cpu_mem_responder #(
    parameter int          IADDR_W  = 8,
    parameter int          DADDR_W  = 8,
    parameter logic [15:0] OUT_ADDR = 16'hFFFF
) (
    input  logic        CK,
    input  logic        RST,
    input  logic [15:0] IA,
    output logic [15:0] ID,
    input  logic [15:0] DA,
    inout  wire  [15:0] DD,
    input  logic        RW,
    input  logic        LD_EN,
    input  logic        LD_VALID,
    input  logic [7:0]  LD_DATA,
    output logic        LD_READY,
    output logic [15:0] LD_COUNT,
    output logic        CPU_RST,
    output logic [15:0] OUT
);
    typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;
    state_t state, state_n;
    logic [IADDR_W-1:0] ptr;
    logic [7:0] hold;
    logic ld_en_q, start, hi_acc, lo_acc, wr_en, is_out;
    logic [15:0] rd;
    logic [15:0] imem [2**IADDR_W];
    logic [15:0] dmem [2**DADDR_W];
    logic unused_ia;
    // Upper instruction address bits are ignored so fetches alias.
    assign unused_ia = ^IA[15:IADDR_W];
    // Dropping LD_EN takes priority over a byte offered in the same cycle.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        hi_acc  = 1'b0;
        lo_acc  = 1'b0;
        case (state)
            IDLE: if (LD_EN) begin
                state_n = HI;
                start   = 1'b1;
            end
            HI: if (!LD_EN) state_n = DONE;
                else if (LD_VALID) begin
                    state_n = LO;
                    hi_acc  = 1'b1;
                end
            LO: if (!LD_EN) state_n = DONE;
                else if (LD_VALID) begin
                    state_n = HI;
                    lo_acc  = 1'b1;
                end
            DONE: if (LD_EN && !ld_en_q) begin
                state_n = HI;
                start   = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    assign CPU_RST  = state != DONE;
    assign LD_READY = state == HI || state == LO;
    assign ID       = imem[IA[IADDR_W-1:0]];
    assign is_out   = DA == OUT_ADDR;
    assign wr_en    = !RW && !CPU_RST;
    assign rd       = is_out ? OUT : dmem[DA[DADDR_W-1:0]];
    assign DD       = RW ? rd : 16'bz;
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ptr      <= '0;
            hold     <= '0;
            LD_COUNT <= '0;
            ld_en_q  <= 1'b0;
            OUT      <= '0;
        end else begin
            state   <= state_n;
            ld_en_q <= LD_EN;
            if (start) begin
                ptr      <= '0;
                LD_COUNT <= '0;
            end else if (lo_acc) begin
                ptr      <= ptr + 1'b1;
                LD_COUNT <= (LD_COUNT == 16'hFFFF) ? LD_COUNT : LD_COUNT + 16'd1;
            end
            if (hi_acc) hold <= LD_DATA;
            if (wr_en && is_out) OUT <= DD;
        end
    end
    // RAMs carry no reset so their contents survive RST.
    always_ff @(posedge CK) begin
        if (lo_acc) imem[ptr] <= {hold, LD_DATA};
        if (wr_en && !is_out) dmem[DA[DADDR_W-1:0]] <= DD;
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed self-checking bench for cpu_mem_responder
module tb_cpu_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ia = '0;
    logic [15:0] id;
    logic [15:0] da = '0;
    wire  [15:0] dd;
    logic [15:0] dd_drv = '0;
    logic        rw = 1'b0;
    logic        ld_en = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready;
    logic [15:0] ld_count;
    logic        cpu_rst;
    logic [15:0] out;
    int          n_chk = 0;
    int          n_fail = 0;
    assign dd = rw ? 16'bz : dd_drv;
    always #5 clk = ~clk;
    cpu_mem_responder dut (
        .CK(clk), .RST(rst), .IA(ia), .ID(id), .DA(da), .DD(dd), .RW(rw),
        .LD_EN(ld_en), .LD_VALID(ld_valid), .LD_DATA(ld_data),
        .LD_READY(ld_ready), .LD_COUNT(ld_count), .CPU_RST(cpu_rst), .OUT(out)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send_byte(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_data  = b;
        step();
        ld_valid = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        rw = 1'b0;
        dd_drv = 16'h5A5A;
        #2;
        n_chk++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_rst got %b want 1", cpu_rst); end
        n_chk++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ld_ready got %b want 0", ld_ready); end
        n_chk++; if (out !== 16'h0000) begin n_fail++; $display("FAIL rst_out got %h want 0000", out); end
        n_chk++; if (ld_count !== 16'h0000) begin n_fail++; $display("FAIL rst_ld_count got %h want 0000", ld_count); end
        n_chk++; if (dd !== 16'h5A5A) begin n_fail++; $display("FAIL rst_dd_released got %h want 5a5a", dd); end
        step();
        rst = 1'b0;
        step();
    endtask
    task automatic test_load_words();
        ld_en = 1'b1;
        step();
        n_chk++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready got %b want 1", ld_ready); end
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        ld_en = 1'b0;
        n_chk++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL load_cpu_rst_held got %b want 1", cpu_rst); end
        step();
        n_chk++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL load_cpu_rst_release got %b want 0", cpu_rst); end
        n_chk++; if (ld_count !== 16'd2) begin n_fail++; $display("FAIL load_count got %h want 0002", ld_count); end
        n_chk++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL load_done_ready got %b want 0", ld_ready); end
        ia = 16'h0000; #1;
        n_chk++; if (id !== 16'h1234) begin n_fail++; $display("FAIL load_imem0 got %h want 1234", id); end
        ia = 16'h0001; #1;
        n_chk++; if (id !== 16'hABCD) begin n_fail++; $display("FAIL load_imem1 got %h want abcd", id); end
        ia = 16'h0101; #1;
        n_chk++; if (id !== 16'hABCD) begin n_fail++; $display("FAIL load_ia_alias got %h want abcd", id); end
    endtask
    task automatic test_partial_load();
        ld_en = 1'b1;
        step();
        n_chk++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL part_cpu_rst_rise got %b want 1", cpu_rst); end
        n_chk++; if (ld_count !== 16'd0) begin n_fail++; $display("FAIL part_count_clear got %h want 0000", ld_count); end
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        ld_en = 1'b0;
        ld_valid = 1'b1;
        ld_data = 8'h44;
        step();
        ld_valid = 1'b0;
        n_chk++; if (ld_count !== 16'd1) begin n_fail++; $display("FAIL part_count got %h want 0001", ld_count); end
        n_chk++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL part_cpu_rst got %b want 0", cpu_rst); end
        ia = 16'h0000; #1;
        n_chk++; if (id !== 16'h1122) begin n_fail++; $display("FAIL part_imem0 got %h want 1122", id); end
        ia = 16'h0001; #1;
        n_chk++; if (id !== 16'hABCD) begin n_fail++; $display("FAIL part_imem1_kept got %h want abcd", id); end
    endtask
    task automatic test_data_path();
        rw = 1'b0; da = 16'h0005; dd_drv = 16'hBEEF;
        step();
        rw = 1'b0; da = 16'h00FF; dd_drv = 16'h0F0F;
        step();
        rw = 1'b1; da = 16'h0005; #1;
        n_chk++; if (dd !== 16'hBEEF) begin n_fail++; $display("FAIL data_read got %h want beef", dd); end
        da = 16'h0105; #1;
        n_chk++; if (dd !== 16'hBEEF) begin n_fail++; $display("FAIL data_alias got %h want beef", dd); end
        rw = 1'b0; da = 16'hFFFF; dd_drv = 16'h00A5;
        step();
        n_chk++; if (out !== 16'h00A5) begin n_fail++; $display("FAIL out_write got %h want 00a5", out); end
        rw = 1'b1; da = 16'h00FF; #1;
        n_chk++; if (dd !== 16'h0F0F) begin n_fail++; $display("FAIL out_dmem_ff_kept got %h want 0f0f", dd); end
        da = 16'hFFFF; #1;
        n_chk++; if (dd !== 16'h00A5) begin n_fail++; $display("FAIL out_read got %h want 00a5", dd); end
    endtask
    task automatic test_reset_reload();
        ld_en = 1'b1;
        step();
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'h99);
        rst = 1'b1; #1;
        n_chk++; if (ld_count !== 16'd0) begin n_fail++; $display("FAIL abort_count got %h want 0000", ld_count); end
        n_chk++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL abort_cpu_rst got %b want 1", cpu_rst); end
        n_chk++; if (out !== 16'h0000) begin n_fail++; $display("FAIL abort_out got %h want 0000", out); end
        ia = 16'h0000; #1;
        n_chk++; if (id !== 16'h7788) begin n_fail++; $display("FAIL abort_imem0_kept got %h want 7788", id); end
        step();
        rst = 1'b0;
        step();
        send_byte(8'h5A);
        send_byte(8'h5B);
        ld_en = 1'b0;
        step();
        n_chk++; if (ld_count !== 16'd1) begin n_fail++; $display("FAIL reload_count got %h want 0001", ld_count); end
        n_chk++; if (id !== 16'h5A5B) begin n_fail++; $display("FAIL reload_ptr_cleared got %h want 5a5b", id); end
        rw = 1'b0; da = 16'h0002; dd_drv = 16'h2222;
        step();
        rw = 1'b1; ld_en = 1'b1;
        step();
        n_chk++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reload_cpu_rst got %b want 1", cpu_rst); end
        rw = 1'b0; da = 16'h0002; dd_drv = 16'h1111;
        step();
        da = 16'hFFFF; dd_drv = 16'hFFFF;
        step();
        rw = 1'b1; ld_en = 1'b0;
        step();
        da = 16'h0002; #1;
        n_chk++; if (dd !== 16'h2222) begin n_fail++; $display("FAIL suppress_dmem got %h want 2222", dd); end
        n_chk++; if (out !== 16'h0000) begin n_fail++; $display("FAIL suppress_out got %h want 0000", out); end
    endtask
    initial begin
        test_reset();
        test_load_words();
        test_partial_load();
        test_data_path();
        test_reset_reload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
